// File: rtl/iob_bus_demux_pkg.sv
// iob_bus_demux_pkg: shared state encoding, bus slot widths and error data for the bus demultiplexer.
package iob_bus_demux_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    // request slot is {valid, address, wdata, wstrb}, response slot is {rdata, ready}
    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction
    function automatic int resp_w(input int dw);
        return dw + 1;
    endfunction
endpackage

// File: rtl/iob_bus_demux_timeout.sv
// iob_bus_demux_timeout: per-transaction cycle counter that flags expiry at TIMEOUT-1; idle when TIMEOUT=0.
module iob_bus_demux_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused;
            assign unused = ^{clk, rst, clr, en};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] cnt;
            always_ff @(posedge clk) begin
                if (rst || clr) cnt <= '0;
                else if (en) cnt <= cnt + 1'b1;
            end
            assign expire = en && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/iob_bus_demux.sv
// iob_bus_demux: routes one master native-bus transaction to one of N_SLAVES slaves by address field,
// with optional boot remap, per-transaction timeout and a registered master response.
module iob_bus_demux
    import iob_bus_demux_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_W = 2,
    parameter int SEL_LSB = 30,
    parameter int BOOT_REMAP = 1,
    parameter int EXT_SLV = 1,
    parameter int BOOT_SLV = 0,
    parameter int TIMEOUT = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF),
    localparam int REQ_W = req_w(ADDR_W, DATA_W),
    localparam int RESP_W = resp_w(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       boot,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err,
    output logic                       busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int N_SEL = 2 ** SEL_W;

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q, m_rdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                err_flag, m_ready_q, err_q, expire;
    logic                ready_v [N_SEL];
    logic [DATA_W-1:0]   rdata_v [N_SEL];

    wire                 m_valid = m_req[REQ_W-1];
    wire [ADDR_W-1:0]    m_addr = m_req[REQ_W-2 -: ADDR_W];
    wire [DATA_W-1:0]    m_wdata = m_req[STRB_W +: DATA_W];
    wire [STRB_W-1:0]    m_wstrb = m_req[STRB_W-1:0];
    wire [SEL_W-1:0]     field = m_addr[SEL_LSB +: SEL_W];
    wire [SEL_W-1:0]     sel_next = (BOOT_REMAP != 0 && boot && field == SEL_W'(EXT_SLV)) ? SEL_W'(BOOT_SLV) : field;
    wire                 bad_sel = int'(sel_next) >= N_SLAVES;

    generate
        for (genvar i = 0; i < N_SEL; i++) begin : g_slot
            if (i < N_SLAVES) begin : g_real
                assign ready_v[i] = s_resp[i*RESP_W];
                assign rdata_v[i] = s_resp[i*RESP_W+1 +: DATA_W];
                // valid is withdrawn in the same cycle the slave answers
                assign s_req[i*REQ_W +: REQ_W] = (state == BUSY && sel == SEL_W'(i)) ?
                    {~ready_v[i], addr_q, wdata_q, wstrb_q} : '0;
            end else begin : g_none
                assign ready_v[i] = 1'b0;
                assign rdata_v[i] = '0;
            end
        end
    endgenerate

    iob_bus_demux_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != BUSY),
        .en     (state == BUSY),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_flag  <= 1'b0;
            m_ready_q <= 1'b0;
            m_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            m_ready_q <= state == RESP;
            err_q     <= state == RESP && err_flag;
            if (state == RESP) m_rdata_q <= err_flag ? ERR_DATA : rdata_q;
            case (state)
                // the master still holds its finished request while ready is visible
                IDLE: if (m_valid && !m_ready_q) begin
                    addr_q   <= m_addr;
                    wdata_q  <= m_wdata;
                    wstrb_q  <= m_wstrb;
                    sel      <= sel_next;
                    err_flag <= bad_sel;
                    state    <= bad_sel ? RESP : BUSY;
                end
                BUSY: if (ready_v[sel]) begin
                    rdata_q <= rdata_v[sel];
                    state   <= RESP;
                end else if (expire) begin
                    err_flag <= 1'b1;
                    state    <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign m_resp = {m_rdata_q, m_ready_q};
    assign err = err_q;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_iob_bus_demux.sv
// tb_iob_bus_demux: directed transactions with a scoreboard of expected master responses.
module tb_iob_bus_demux;
    localparam int N = 3;
    localparam int TO = 16;
    localparam int REQ_W = 69;
    localparam int RESP_W = 33;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_data;
        logic        err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                boot = 1'b0;
    logic [REQ_W-1:0]    m_req = '0;
    logic [RESP_W-1:0]   m_resp;
    logic [N*REQ_W-1:0]  s_req;
    logic [N*RESP_W-1:0] s_resp = '0;
    logic                err, busy;
    int                  tests = 0;
    int                  fails = 0;
    exp_t                sb[$];

    always #5 clk = ~clk;

    iob_bus_demux #(
        .ADDR_W(32), .DATA_W(32), .N_SLAVES(N), .SEL_W(2), .SEL_LSB(30),
        .BOOT_REMAP(1), .EXT_SLV(1), .BOOT_SLV(0), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst(rst), .boot(boot), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .err(err), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lat = cycles the slave sees valid before answering; 0 = slave never answers
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic b, input int lat, input logic [31:0] rd, input string tag);
        logic [1:0] field, sel;
        logic       bad, done, slot_ok, others_ok;
        int         cyc, vcnt, exp_lat, exp_v;
        exp_t       e;
        field = addr[31:30];
        sel = (b && field == 2'd1) ? 2'd0 : field;
        bad = int'(sel) >= N;
        exp_lat = bad ? 2 : (lat == 0 ? TO + 2 : lat + 2);
        exp_v = bad ? 0 : (lat == 0 ? TO : lat);
        e.err = bad || lat == 0;
        e.rdata = e.err ? 32'hDEADBEEF : rd;
        e.chk_data = e.err || wstrb == 4'h0;
        sb.push_back(e);
        boot = b;
        m_req = {1'b1, addr, wdata, wstrb};
        cyc = 0; vcnt = 0; done = 0; slot_ok = 1; others_ok = 1;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            boot = ~b;
            s_resp = '0;
            if (cyc == 1) check({tag, "_busy"}, busy, 1'b1);
            if (m_resp[0]) done = 1;
            else for (int i = 0; i < N; i++) begin
                if (i == int'(sel) && !bad) begin
                    if (s_req[i*REQ_W+REQ_W-1]) begin
                        vcnt++;
                        if (s_req[i*REQ_W +: REQ_W] !== {1'b1, addr, wdata, wstrb}) slot_ok = 0;
                        if (vcnt == lat) s_resp[i*RESP_W +: RESP_W] = {rd, 1'b1};
                    end
                end else if (s_req[i*REQ_W +: REQ_W] !== '0) others_ok = 0;
            end
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_valid_cycles"}, vcnt, exp_v);
        check({tag, "_slot_content"}, slot_ok, 1'b1);
        check({tag, "_other_slots"}, others_ok, 1'b1);
        e = sb.pop_front();
        if (done) begin
            check({tag, "_err"}, err, e.err);
            if (e.chk_data) check({tag, "_rdata"}, m_resp[32:1], e.rdata);
        end
        m_req = '0;
        @(negedge clk);
        check({tag, "_ready_pulse"}, {m_resp[0], err}, 2'b00);
    endtask

    initial begin
        logic ok;
        repeat (3) @(negedge clk);
        check("reset_m_resp", m_resp, '0);
        check("reset_s_req", s_req, '0);
        check("reset_err_busy", {err, busy}, 2'b00);
        rst = 1'b0;

        txn(32'h8000_0010, 32'h0, 4'h0, 1'b0, 2, 32'h1234_5678, "rd_s2");
        txn(32'h4000_0004, 32'hA5A5_A5A5, 4'hF, 1'b0, 1, 32'h0, "wr_s1");
        txn(32'h4000_0000, 32'h0, 4'h0, 1'b1, 1, 32'h0BEE_0000, "boot_s0");
        txn(32'h4000_0000, 32'h0, 4'h0, 1'b0, 3, 32'h1111_2222, "noboot_s1");
        txn(32'h8000_0000, 32'h0, 4'h0, 1'b1, 2, 32'h3333_4444, "boot_s2");
        txn(32'hC000_0000, 32'h0, 4'h0, 1'b0, 1, 32'h5555_6666, "bad_sel");
        txn(32'h0000_0008, 32'h0, 4'h0, 1'b0, 0, 32'h7777_8888, "timeout");

        ok = 1;
        for (int k = 0; k < 3; k++) begin
            s_resp[0] = 1'b1;
            s_resp[RESP_W +: RESP_W] = {32'h9999_0000, 1'b1};
            @(negedge clk);
            if (m_resp[0] || err || busy || s_req !== '0) ok = 0;
        end
        s_resp = '0;
        check("stray_ready_ignored", ok, 1'b1);

        m_req = {1'b1, 32'h8000_0010, 32'h0, 4'h0};
        repeat (3) @(negedge clk);
        check("pre_rst_valid", s_req[2*REQ_W+REQ_W-1], 1'b1);
        rst = 1'b1;
        m_req = '0;
        @(negedge clk);
        check("rst_abort", {s_req, busy, m_resp[0]}, '0);
        rst = 1'b0;
        ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (m_resp[0] || busy) ok = 0;
        end
        check("rst_no_ready", ok, 1'b1);
        txn(32'h8000_0020, 32'h0, 4'h0, 1'b0, 1, 32'hCAFE_F00D, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
